// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, counter debounce, and per-channel
// rise/fall pulses, toggle state and a single long-press pulse.
module debounce_multi #(
  parameter int unsigned N_CH        = 5,
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned LONG_CYCLES = 100_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw_i,
  input  logic [N_CH-1:0] tgl_clr_i,
  output logic [N_CH-1:0] btn_level_o,
  output logic [N_CH-1:0] btn_rise_o,
  output logic [N_CH-1:0] btn_fall_o,
  output logic [N_CH-1:0] btn_toggle_o,
  output logic [N_CH-1:0] btn_long_o
);

  localparam int unsigned CntW  = $clog2(DB_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             prev_q;
    logic             tgl_q, tgl_d;
    logic             rise, fall;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;

    assign rise = lvl_q & ~prev_q;
    assign fall = ~lvl_q & prev_q;

    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      hold_d = '0;
      // Counter only runs while the synchronised input disagrees with the accepted level;
      // any agreement (bounce back) drops it to zero.
      if (s2_q != lvl_q) begin
        if (cnt_q == CntLast) begin
          lvl_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (lvl_q) begin
        hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
      end
      // Clear takes priority over a simultaneous rise.
      tgl_d = tgl_clr_i[ch] ? 1'b0 : (tgl_q ^ rise);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        tgl_q  <= 1'b0;
        cnt_q  <= '0;
        hold_q <= '0;
      end else begin
        s1_q   <= btn_raw_i[ch];
        s2_q   <= s1_q;
        lvl_q  <= lvl_d;
        prev_q <= lvl_q;
        tgl_q  <= tgl_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
      end
    end

    assign btn_level_o[ch]  = lvl_q;
    assign btn_rise_o[ch]   = rise;
    assign btn_fall_o[ch]   = fall;
    assign btn_toggle_o[ch] = tgl_q;
    // Fires in the cycle whose edge moves the hold counter onto LONG_CYCLES.
    assign btn_long_o[ch]   = lvl_q & (hold_q == HoldLast);
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bouncing stimulus, every cycle
// compared against a window-based reference model of the button conditioner.
module tb_debounce_multi;

  localparam int unsigned NCh  = 2;
  localparam int unsigned Db   = 4;
  localparam int unsigned Long = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw, tgl_clr;
  logic [1:0] level, rise, fall, toggle, long_p;

  debounce_multi #(
    .N_CH       (NCh),
    .DB_CYCLES  (Db),
    .LONG_CYCLES(Long)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw_i   (btn_raw),
    .tgl_clr_i   (tgl_clr),
    .btn_level_o (level),
    .btn_rise_o  (rise),
    .btn_fall_o  (fall),
    .btn_toggle_o(toggle),
    .btn_long_o  (long_p)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_cnt[2], fall_cnt[2], long_cnt[2];

  // Reference model: ago[ch][j] is the raw value sampled j+1 edges ago. A level is accepted
  // once the last Db synchronised samples (raw delayed by two edges) all disagree with it.
  bit ago[2][Db+1];
  bit m_lvl[2], m_prev[2], m_tgl[2];
  int m_age[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int j = 0; j <= Db; j++) ago[ch][j] = 1'b0;
      m_lvl[ch]  = 1'b0;
      m_prev[ch] = 1'b0;
      m_tgl[ch]  = 1'b0;
      m_age[ch]  = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      bit accept = 1'b1;
      bit m_rise = m_lvl[ch] && !m_prev[ch];
      for (int j = 1; j <= Db; j++) if (ago[ch][j] == m_lvl[ch]) accept = 1'b0;
      m_tgl[ch] = tgl_clr[ch] ? 1'b0 : (m_tgl[ch] ^ m_rise);
      if (m_lvl[ch]) m_age[ch] = (m_age[ch] < int'(Long)) ? m_age[ch] + 1 : int'(Long);
      else m_age[ch] = 0;
      m_prev[ch] = m_lvl[ch];
      if (accept) m_lvl[ch] = !m_lvl[ch];
      for (int j = Db; j >= 1; j--) ago[ch][j] = ago[ch][j-1];
      ago[ch][0] = btn_raw[ch];
    end
  endfunction

  task automatic check_all();
    logic [1:0] e_lvl, e_rise, e_fall, e_tgl, e_long;
    for (int ch = 0; ch < 2; ch++) begin
      e_lvl[ch]  = m_lvl[ch];
      e_rise[ch] = m_lvl[ch] && !m_prev[ch];
      e_fall[ch] = !m_lvl[ch] && m_prev[ch];
      e_tgl[ch]  = m_tgl[ch];
      e_long[ch] = m_lvl[ch] && (m_age[ch] == int'(Long) - 1);
      rise_cnt[ch] += int'(rise[ch]);
      fall_cnt[ch] += int'(fall[ch]);
      long_cnt[ch] += int'(long_p[ch]);
    end
    check("level", level, e_lvl);
    check("rise", rise, e_rise);
    check("fall", fall, e_fall);
    check("toggle", toggle, e_tgl);
    check("long", long_p, e_long);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_cnt();
    for (int ch = 0; ch < 2; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
      long_cnt[ch] = 0;
    end
  endtask

  // Advance until the model says channel ch is in its rise cycle (bounded).
  task automatic wait_rise(input int ch);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_lvl[ch] && !m_prev[ch]) found = 1'b1;
      else tick();
    end
    if (!found) check("wait_rise_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level", level, 2'b00);
    check("rst_async_rise", rise, 2'b00);
    check("rst_async_fall", fall, 2'b00);
    check("rst_async_toggle", toggle, 2'b00);
    check("rst_async_long", long_p, 2'b00);
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    tgl_clr = 2'b00;
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(3);

    // Clean press on ch0 held 30 cycles.
    clear_cnt();
    btn_raw[0] = 1'b1;
    run(30);
    check("s1_rise_cnt", rise_cnt[0], 1);
    check("s1_long_cnt", long_cnt[0], 1);
    check("s1_toggle", toggle[0], 1'b1);
    check("s1_ch1_quiet", rise_cnt[1] + long_cnt[1] + int'(level[1]), 0);
    btn_raw[0] = 1'b0;
    run(10);

    // Bouncing press on ch0.
    clear_cnt();
    btn_raw[0] = 1'b1; run(3);
    btn_raw[0] = 1'b0; run(1);
    btn_raw[0] = 1'b1; run(2);
    btn_raw[0] = 1'b0; run(1);
    btn_raw[0] = 1'b1; run(20);
    check("s2_rise_cnt", rise_cnt[0], 1);
    btn_raw[0] = 1'b0;
    run(10);

    // Two short press/release cycles on ch1.
    clear_cnt();
    repeat (2) begin
      btn_raw[1] = 1'b1; run(6);
      btn_raw[1] = 1'b0; run(12);
    end
    check("s3_rise_cnt", rise_cnt[1], 2);
    check("s3_fall_cnt", fall_cnt[1], 2);
    check("s3_long_cnt", long_cnt[1], 0);
    check("s3_toggle", toggle[1], 1'b0);
    check("s3_level", level[1], 1'b0);

    // Clear coincident with rise, then clear alone.
    btn_raw[0] = 1'b1;
    wait_rise(0);
    tgl_clr[0] = 1'b1;
    tick();
    tgl_clr[0] = 1'b0;
    check("s4_clr_wins", toggle[0], 1'b0);
    btn_raw[0] = 1'b0; run(10);
    btn_raw[0] = 1'b1; run(10);
    check("s4_toggle_set", toggle[0], 1'b1);
    tgl_clr[0] = 1'b1;
    tick();
    tgl_clr[0] = 1'b0;
    check("s4_clr_alone", toggle[0], 1'b0);
    btn_raw[0] = 1'b0;
    run(10);

    // Simultaneous rise on both channels.
    btn_raw = 2'b11;
    wait_rise(0);
    check("s5_rise_both", rise, 2'b11);
    tick();
    check("s5_toggle_both", toggle, 2'b11);

    // Reset in the middle of a held press.
    run(3);
    pulse_reset();
    clear_cnt();
    run(12);
    check("s6_rise_cnt", rise_cnt[0], 1);
    check("s6_toggle", toggle, 2'b11);
    btn_raw = 2'b00;
    run(10);

    // Random bouncing with random clears and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned den = $urandom_range(12, 2);
      for (int c = 0; c < 100; c++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if ($urandom_range(den - 1, 0) == 0) btn_raw[ch] = ~btn_raw[ch];
          tgl_clr[ch] = ($urandom_range(7, 0) == 0);
        end
        tick();
        if ($urandom_range(299, 0) == 0) pulse_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
